// File: rtl/multisim_pull_downsizer.sv
// Width down-converter: buffers up to two wide words and replays each one as
// IN_WIDTH/OUT_WIDTH narrow beats, least-significant slice first.
module multisim_pull_downsizer #(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last
);

    localparam int unsigned BEATS  = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    generate
        if (OUT_WIDTH == 0 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
            $error("IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
        end
    endgenerate

    logic [IN_WIDTH-1:0] entry [2];
    logic                wp, wp_next;
    logic                rp, rp_next;
    logic [1:0]          cnt, cnt_next;
    logic [BEAT_W-1:0]   beat, beat_next;

    logic                push;
    logic                pop;
    logic                beat_xfer;
    logic                at_last;
    logic [IN_WIDTH-1:0] head;
    int unsigned         lsb;

    // in_rdy looks only at registered occupancy so out_rdy never reaches it.
    always_comb begin
        in_rdy    = (cnt != 2'd2) && !rst;
        out_vld   = (cnt != 2'd0);
        at_last   = (beat == LAST_BEAT);
        out_last  = out_vld && at_last;
        push      = in_vld && in_rdy;
        beat_xfer = out_vld && out_rdy;
        pop       = beat_xfer && at_last;
        head      = entry[rp];
        lsb       = 32'(beat) * OUT_WIDTH;
        out_data  = head[lsb +: OUT_WIDTH];
    end

    always_comb begin
        wp_next   = wp;
        rp_next   = rp;
        beat_next = beat;
        cnt_next  = cnt;
        if (push) begin
            wp_next = ~wp;
        end
        if (pop) begin
            rp_next = ~rp;
        end
        if (beat_xfer) begin
            beat_next = at_last ? '0 : beat + BEAT_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_next = cnt + 2'd1;
            2'b01:   cnt_next = cnt - 2'd1;
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp   <= 1'b0;
            rp   <= 1'b0;
            cnt  <= 2'd0;
            beat <= '0;
        end else begin
            wp   <= wp_next;
            rp   <= rp_next;
            cnt  <= cnt_next;
            beat <= beat_next;
        end
    end

    // Payload storage carries no reset; it is only observed while out_vld is high.
    always_ff @(posedge clk) begin
        if (push) begin
            entry[wp] <= in_data;
        end
    end

endmodule

// File: tb/tb_multisim_pull_downsizer.sv
// Directed bench for the width down-converter: a queue-based model checked every
// cycle, plus literal beat expectations for each scenario, on 64/16 and 64/64 builds.
module tb_multisim_pull_downsizer;

    localparam int BEATS = 4;

    logic        clk;
    logic        rst;
    logic        in_vld, in_rdy, out_vld, out_rdy, out_last;
    logic [63:0] in_data;
    logic [15:0] out_data;
    logic        w_in_vld, w_in_rdy, w_out_vld, w_out_rdy, w_out_last;
    logic [63:0] w_in_data, w_out_data;

    int vectors = 0;
    int miscompares = 0;

    multisim_pull_downsizer #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last)
    );

    multisim_pull_downsizer #(.IN_WIDTH(64), .OUT_WIDTH(64)) dut_w (
        .clk(clk), .rst(rst), .in_vld(w_in_vld), .in_rdy(w_in_rdy), .in_data(w_in_data),
        .out_vld(w_out_vld), .out_rdy(w_out_rdy), .out_data(w_out_data),
        .out_last(w_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model: words waiting to be emitted, plus how many beats of the head are gone.
    logic [63:0] mq[$];
    int          mbeat;
    logic [63:0] wq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            wq.delete();
            mbeat <= 0;
        end else begin
            automatic bit n_push = in_vld && (mq.size() < 2);
            automatic bit w_push = w_in_vld && (wq.size() < 2);
            if (mq.size() != 0 && out_rdy) begin
                if (mbeat == BEATS - 1) begin
                    void'(mq.pop_front());
                    mbeat <= 0;
                end else begin
                    mbeat <= mbeat + 1;
                end
            end
            if (n_push) mq.push_back(in_data);
            if (wq.size() != 0 && w_out_rdy) void'(wq.pop_front());
            if (w_push) wq.push_back(w_in_data);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_in_rdy", 64'(in_rdy), 64'(mq.size() < 2));
            chk("mdl_out_vld", 64'(out_vld), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("mdl_out_data", 64'(out_data), 64'(mq[0][mbeat*16 +: 16]));
                chk("mdl_out_last", 64'(out_last), 64'(mbeat == BEATS - 1));
            end
            chk("mdl_w_in_rdy", 64'(w_in_rdy), 64'(wq.size() < 2));
            chk("mdl_w_out_vld", 64'(w_out_vld), 64'(wq.size() != 0));
            if (wq.size() != 0) begin
                chk("mdl_w_out_data", w_out_data, wq[0]);
                chk("mdl_w_out_last", 64'(w_out_last), 64'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check the visible beat, then advance one cycle.
    task automatic see(input string nm, input logic [15:0] d, input logic last);
        chk({nm, "_vld"}, 64'(out_vld), 64'd1);
        chk({nm, "_data"}, 64'(out_data), 64'(d));
        chk({nm, "_last"}, 64'(out_last), 64'(last));
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t2_exp [8];
        t2_exp = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3,
                   16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3};
        rst = 1'b1;
        in_vld = 1'b0; out_rdy = 1'b0; in_data = '0;
        w_in_vld = 1'b0; w_out_rdy = 1'b0; w_in_data = '0;
        repeat (2) cyc();
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_rdy", 64'(in_rdy), 64'd1);
        cyc();

        // 1: basic unpack
        in_data = 64'h4444_3333_2222_1111; in_vld = 1'b1; out_rdy = 1'b1;
        cyc();
        in_vld = 1'b0;
        see("t1b0", 16'h1111, 1'b0);
        see("t1b1", 16'h2222, 1'b0);
        see("t1b2", 16'h3333, 1'b0);
        see("t1b3", 16'h4444, 1'b1);
        chk("t1_idle", 64'(out_vld), 64'd0);

        // 2: fill and backpressure
        out_rdy = 1'b0;
        in_data = 64'hA3A3_A2A2_A1A1_A0A0; in_vld = 1'b1;
        cyc();
        chk("t2_rdy1", 64'(in_rdy), 64'd1);
        in_data = 64'hB3B3_B2B2_B1B1_B0B0;
        cyc();
        chk("t2_full", 64'(in_rdy), 64'd0);
        in_data = 64'hCCCC_CCCC_CCCC_CCCC;
        cyc();
        chk("t2_still_full", 64'(in_rdy), 64'd0);
        chk("t2_head", 64'(out_data), 64'hA0A0);
        in_vld = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) chk("t2_rdy_before_pop", 64'(in_rdy), 64'd0);
            if (i == 4) chk("t2_rdy_after_pop", 64'(in_rdy), 64'd1);
            see("t2", t2_exp[i], i == 3 || i == 7);
        end
        chk("t2_idle", 64'(out_vld), 64'd0);

        // 3: stall mid-word
        in_data = 64'hDDDD_CCCC_2222_1111; in_vld = 1'b1;
        cyc();
        in_vld = 1'b0;
        see("t3b0", 16'h1111, 1'b0);
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_data", 64'(out_data), 64'h2222);
            chk("t3_stall_beat", 64'(dut.beat), 64'd1);
            chk("t3_stall_last", 64'(out_last), 64'd0);
            cyc();
        end
        out_rdy = 1'b1;
        see("t3b1", 16'h2222, 1'b0);
        see("t3b2", 16'hCCCC, 1'b0);
        see("t3b3", 16'hDDDD, 1'b1);
        chk("t3_idle", 64'(out_vld), 64'd0);

        // 4: push on the same edge as the final-beat pop
        in_data = 64'h5555_4444_3333_2222; in_vld = 1'b1;
        cyc();
        in_vld = 1'b0;
        see("t4b0", 16'h2222, 1'b0);
        see("t4b1", 16'h3333, 1'b0);
        see("t4b2", 16'h4444, 1'b0);
        chk("t4_last_data", 64'(out_data), 64'h5555);
        chk("t4_last", 64'(out_last), 64'd1);
        chk("t4_cnt_before", 64'(dut.cnt), 64'd1);
        in_data = 64'hC3C3_C2C2_C1C1_C0C0; in_vld = 1'b1;
        cyc();
        in_vld = 1'b0;
        chk("t4_cnt_after", 64'(dut.cnt), 64'd1);
        see("t4c0", 16'hC0C0, 1'b0);
        see("t4c1", 16'hC1C1, 1'b0);
        see("t4c2", 16'hC2C2, 1'b0);
        see("t4c3", 16'hC3C3, 1'b1);
        chk("t4_idle", 64'(out_vld), 64'd0);

        // 5: asynchronous reset mid-word with two words buffered
        out_rdy = 1'b0;
        in_data = 64'hE3E3_E2E2_E1E1_E0E0; in_vld = 1'b1;
        cyc();
        in_data = 64'hF3F3_F2F2_F1F1_F0F0;
        cyc();
        in_vld = 1'b0; out_rdy = 1'b1;
        see("t5b0", 16'hE0E0, 1'b0);
        see("t5b1", 16'hE1E1, 1'b0);
        chk("t5b2_data", 64'(out_data), 64'hE2E2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_out_vld", 64'(out_vld), 64'd0);
        chk("t5_rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("t5_rst_out_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t5_cnt", 64'(dut.cnt), 64'd0);
        chk("t5_rel_in_rdy", 64'(in_rdy), 64'd1);
        chk("t5_rel_out_vld", 64'(out_vld), 64'd0);
        in_data = 64'h9999_8888_7777_6666; in_vld = 1'b1;
        cyc();
        in_vld = 1'b0;
        see("t5d0", 16'h6666, 1'b0);
        see("t5d1", 16'h7777, 1'b0);
        see("t5d2", 16'h8888, 1'b0);
        see("t5d3", 16'h9999, 1'b1);
        chk("t5_idle", 64'(out_vld), 64'd0);

        // 6: OUT_WIDTH == IN_WIDTH behaves as a 2-entry FIFO
        w_in_data = 64'h0123_4567_89AB_CDEF; w_in_vld = 1'b1;
        cyc();
        chk("t6_lat_vld", 64'(w_out_vld), 64'd1);
        chk("t6_lat_data", w_out_data, 64'h0123_4567_89AB_CDEF);
        chk("t6_lat_last", 64'(w_out_last), 64'd1);
        w_in_data = 64'hFEDC_BA98_7654_3210;
        cyc();
        chk("t6_full", 64'(w_in_rdy), 64'd0);
        w_in_vld = 1'b0; w_out_rdy = 1'b1;
        cyc();
        chk("t6_second", w_out_data, 64'hFEDC_BA98_7654_3210);
        chk("t6_second_last", 64'(w_out_last), 64'd1);
        cyc();
        chk("t6_idle", 64'(w_out_vld), 64'd0);
        w_in_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_in_data = 64'h1000 + 64'(i);
            cyc();
            chk("t6_stream", w_out_data, 64'h1000 + 64'(i));
        end
        w_in_vld = 1'b0;
        cyc();
        chk("t6_stream_idle", 64'(w_out_vld), 64'd0);
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multisim_pull_downsizer.md
# multisim_pull_downsizer

Stream width down-converter sitting directly downstream of the multisim pull client. It accepts wide words on a valid/ready handshake and replays each word as `IN_WIDTH/OUT_WIDTH` narrow beats, least-significant slice first, to the DUT-side consumer. A 2-entry input buffer keeps `in_rdy` free of any combinational path from `out_rdy`, so the client's posedge-sampled ready stays glitch-free.

## Interface

- `IN_WIDTH`, default 64: width of the words arriving from the pull client.
- `OUT_WIDTH`, default 16: width of each emitted beat. `IN_WIDTH % OUT_WIDTH` must be 0; elaboration fails otherwise.
- Derived: `BEATS = IN_WIDTH/OUT_WIDTH`. `BEATS=1` is legal and gives a pure 2-entry buffer.

Ports:

- `clk` input, 1 bit: the single clock. All logic is on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_vld` input, 1 bit: an upstream word is valid. Driven by the client's `data_vld`.
- `in_rdy` output, 1 bit: the block can accept a word. Feeds the client's `data_rdy`.
- `in_data` input, `IN_WIDTH` bits: the upstream word.
- `out_vld` output, 1 bit: the current beat is valid.
- `out_rdy` input, 1 bit: the downstream consumer accepts the beat.
- `out_data` output, `OUT_WIDTH` bits: the current beat.
- `out_last` output, 1 bit: high on the final beat of a word.

## Operation

**Storage**
- Two word entries with write pointer `wp`, read pointer `rp`, occupancy `cnt` (0..2) and beat index `beat` (0..BEATS-1).
- All of these are flops.

**Input side**
- `in_rdy = (cnt != 2) && !rst`.
- A push occurs when `in_vld && in_rdy` at a rising edge. The push writes `in_data` to entry `wp` and toggles `wp`.

**Output side**
- `out_vld = (cnt != 0)`.
- `out_data = head[beat*OUT_WIDTH +: OUT_WIDTH]`, where `head` is entry `rp`.
- `out_last = out_vld && (beat == BEATS-1)`.

**Beat handshake** (a beat transfers when `out_vld && out_rdy` at a rising edge)
- If `beat < BEATS-1`: increment `beat`.
- Otherwise: clear `beat` to 0 and pop the head (toggle `rp`).

**Occupancy update**
- `cnt` gains 1 on a push and loses 1 on a pop.
- A simultaneous push and pop leaves `cnt` unchanged.
- A push with `cnt==1` and a same-cycle final-beat pop is legal. The new word becomes the head the following cycle.

**Reset**
- `rst` asserted clears `cnt`, `wp`, `rp` and `beat` immediately.
- Outputs while in reset: `out_vld=0`, `out_last=0`, `in_rdy=0`.
- Entry contents are not reset. `out_data` is don't-care while `out_vld=0`.
- Reset asserted mid-word discards the remaining beats and any buffered words. There is no partial replay after reset.

**Data integrity and stalls**
- Data is never dropped or reordered.
- `out_rdy` low holds `out_data`, `out_last` and `beat` stable.

## Timing

- **Push-to-beat latency:** 1 cycle. A word pushed at edge N drives beat 0 on `out_vld` from just after edge N.
- **Throughput:** one beat per cycle when `out_rdy=1`. A word occupies the output for exactly `BEATS` accepted beats.
- **Back-to-back words:** no bubble between the last beat of word k and beat 0 of word k+1 when word k+1 is already buffered.
- **Upstream rate:** the input accepts one word per cycle while `cnt<2`. Sustained upstream rate with `out_rdy=1` is one word per `BEATS` cycles.
- **Registered ready:** `in_rdy` depends only on registered `cnt` and `rst`, so there is no same-cycle path from `out_rdy`. A pop at edge N raises `in_rdy` after edge N.
- **Reset release:** `in_rdy` rises combinationally at `rst` deassertion. The first push can occur at the first rising edge after release.

## Test plan

1. **Basic unpack.** `IN_WIDTH=64`, `OUT_WIDTH=16`, push `0x4444_3333_2222_1111` with `out_rdy=1`.
   - Required: beats `0x1111, 0x2222, 0x3333, 0x4444` on 4 consecutive cycles.
   - Required: `out_last` only on `0x4444`; `out_vld` low after.
2. **Fill and backpressure.** Hold `out_rdy=0` and push words A then B.
   - Required: `in_rdy` drops to 0 after the second push; a third `in_vld` is not accepted.
   - Then raise `out_rdy`: 8 beats emerge A then B with no gap, and `in_rdy` returns to 1 after A's last beat.
3. **Stall mid-word.** Drop `out_rdy` for 3 cycles after beat 1 of `0x…_2222_1111`.
   - Required: `out_data` stays `0x2222` and `beat` is unchanged throughout the stall.
   - Then beats 2 and 3 follow.
4. **Simultaneous push/pop at `cnt==1`.** Push word C on the same edge as A's last-beat pop.
   - Required: `cnt` stays 1.
   - Required: C beat 0 appears the next cycle with no bubble.
5. **Reset mid-operation.** Assert `rst` asynchronously (between edges) during beat 2 with 2 words buffered.
   - Required: `out_vld=0` and `in_rdy=0` immediately.
   - After release: `cnt=0`; the next pushed word starts at beat 0.
6. **Degenerate width.** `OUT_WIDTH=64`.
   - Required: every beat has `out_last=1`; the block behaves as a 2-entry FIFO with 1-cycle latency.
